// File: rtl/rom_scan_ctrl_pkg.sv
// Shared types and constants for the ROM scan controller.
package rom_scan_ctrl_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 16;
   localparam int FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_t;

endpackage

// File: rtl/rom_scan_ctrl_if.sv
// Command, ROM read port and output stream of the ROM scan controller.
interface rom_scan_ctrl_if
   import rom_scan_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   length;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              busy;
   logic              done;

   modport slave (
      input  start, start_addr, length, rom_data, out_ready,
      output rom_en, rom_addr, out_valid, out_data, out_addr, busy, done
   );

   modport master (
      output start, start_addr, length, rom_data, out_ready,
      input  rom_en, rom_addr, out_valid, out_data, out_addr, busy, done
   );
endinterface

// File: rtl/rom_scan_fifo.sv
// Small output FIFO holding ROM words together with the address they came from.
module rom_scan_fifo
   import rom_scan_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               push,
   input  logic [DATA_W-1:0]                  push_data,
   input  logic [ADDR_W-1:0]                  push_addr,
   input  logic                               pop,
   output logic                               valid,
   output logic [DATA_W-1:0]                  head_data,
   output logic [ADDR_W-1:0]                  head_addr,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ENT_W = ADDR_W + DATA_W;

   logic [FIFO_DEPTH-1:0][ENT_W-1:0] entries;
   logic [PTR_W-1:0]                 wr_ptr_reg;
   logic [PTR_W-1:0]                 rd_ptr_reg;
   logic [CNT_W-1:0]                 count_reg;
   logic                             do_pop;

   assign do_pop = pop && (count_reg != '0);

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         logic [ENT_W-1:0] entry_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               entry_reg <= '0;
            else if (push && (wr_ptr_reg == PTR_W'(gi)))
               entry_reg <= {push_addr, push_data};
         end
         assign entries[gi] = entry_reg;
      end
   endgenerate

   // Pointers wrap by natural overflow, so the depth must stay a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign valid                  = (count_reg != '0);
   assign count                  = count_reg;
   assign {head_addr, head_data} = entries[rd_ptr_reg];

endmodule

// File: rtl/rom_scan_ctrl.sv
// Streams a contiguous (wrapping) range of a 1-cycle-latency ROM out through a ready/valid port.
module rom_scan_ctrl
   import rom_scan_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic           clk,
   input  logic           rst_n,
   rom_scan_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   scan_state_t       state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W:0]   reads_left_reg;
   logic              in_flight_reg;
   logic [ADDR_W-1:0] in_flight_addr_reg;
   logic              fifo_valid;
   logic [DATA_W-1:0] fifo_data;
   logic [ADDR_W-1:0] fifo_addr;
   logic [CNT_W-1:0]  fifo_count;
   logic              pop;
   logic              issue;
   logic              credit_ok;
   logic [CNT_W:0]    occupancy;
   logic              rom_en_next;
   logic              busy_next;
   logic              done_next;

   assign pop = fifo_valid && bus.out_ready;

   // A word leaving this cycle frees its slot, so it counts as credit; this keeps the stream gap-free at out_ready=1.
   assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, in_flight_reg} - {{CNT_W{1'b0}}, pop};
   assign credit_ok = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
   assign issue     = (state_reg == ST_RUN) && (reads_left_reg != '0) && credit_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      rom_en_next = 1'b0;
      busy_next   = 1'b0;
      done_next   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start)
               state_next = (bus.length != '0) ? ST_RUN : ST_DONE;
         end
         ST_RUN: begin
            rom_en_next = issue;
            busy_next   = 1'b1;
            if (issue && (reads_left_reg == (ADDR_W + 1)'(1)))
               state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy_next = 1'b1;
            // Leave as the last buffered word is taken so done follows it by one cycle.
            if (!in_flight_reg && ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop)))
               state_next = ST_DONE;
         end
         ST_DONE: begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg           <= '0;
         reads_left_reg     <= '0;
         in_flight_reg      <= 1'b0;
         in_flight_addr_reg <= '0;
      end else begin
         in_flight_reg <= issue;
         if ((state_reg == ST_IDLE) && bus.start) begin
            addr_reg       <= bus.start_addr;
            reads_left_reg <= bus.length;
         end else if (issue) begin
            in_flight_addr_reg <= addr_reg;
            addr_reg           <= addr_reg + ADDR_W'(1);
            reads_left_reg     <= reads_left_reg - (ADDR_W + 1)'(1);
         end
      end
   end

   rom_scan_fifo #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_flight_reg),
      .push_data (bus.rom_data),
      .push_addr (in_flight_addr_reg),
      .pop       (pop),
      .valid     (fifo_valid),
      .head_data (fifo_data),
      .head_addr (fifo_addr),
      .count     (fifo_count)
   );

   assign bus.rom_en    = rom_en_next;
   assign bus.rom_addr  = addr_reg;
   assign bus.out_valid = fifo_valid;
   assign bus.out_data  = fifo_data;
   assign bus.out_addr  = fifo_addr;
   assign bus.busy      = busy_next;
   assign bus.done      = done_next;

endmodule
